program_sequencer_ctrl: RTL and testbench
=========================================

PROGRAM_SEQUENCER_CTRL -- requirements
Module: program_sequencer_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and sync_reset.
REQ-002 Port: clk  input  1  rising-edge clock; all state updates on this edge only.
REQ-003 Port: sync_reset  input  1  synchronous active-high reset.
REQ-004 Port: jmp  input  1  unconditional jump request from the instruction decoder.
REQ-005 Port: jmp_nz  input  1  conditional jump request (taken when dont_jmp=0).
REQ-006 Port: call  input  1  subroutine call request (target formed as for jmp).
REQ-007 Port: ret  input  1  subroutine return request.
REQ-008 Port: jmp_addr  input  4  low nibble of the target address (decoder ir_nibble).
REQ-009 Port: dont_jmp  input  1  ALU zero flag; 1 suppresses jmp_nz.
REQ-010 Port: hold  input  1  stall request; freezes sequencing.
REQ-011 Port: pm_addr  output  8  combinational program-memory address for the next fetch.
REQ-012 Port: pc  output  8  registered program counter, the address of the instruction in ir.
REQ-013 Port: from_PS  output  8  debug copy of pc.
REQ-014 Port: sp  output  3  stack occupancy, 0..4.
REQ-015 Port: stack_err  output  1  sticky overflow/underflow flag.

Function
REQ-016 pc SHALL load pm_addr on every clk edge; hold is the only exception (REQ-020).
REQ-017 pm_addr SHALL be selected by fixed priority: sync_reset > hold > ret > call > jmp > jmp_nz-taken > increment.
REQ-018 Jump or call target SHALL be {pc[7:4], jmp_addr}: a page-relative jump within the current 16-word page.
REQ-019 Increment SHALL be pc+1 modulo 256: 8'hFF wraps to 8'h00, with no flag raised.
REQ-020 hold=1 SHALL force pm_addr=pc and freeze pc, sp, stack contents and stack_err; other requests in that cycle are ignored.
REQ-021 jmp_nz SHALL be taken only when dont_jmp=0; when not taken, pm_addr=pc+1.
REQ-022 The return stack SHALL hold 4 entries of 8 bits each, in LIFO order.
REQ-023 A call with sp<4 SHALL push pc+1, increment sp and select the call target.
REQ-024 A call with sp=4 SHALL still select the call target, drop the push, leave sp=4 and set stack_err.
REQ-025 A ret with sp>0 SHALL select the top entry as pm_addr and decrement sp.
REQ-026 A ret with sp=0 SHALL select pc+1, leave sp=0 and set stack_err.
REQ-027 When call and ret are asserted together, ret SHALL win and call SHALL have no effect.
REQ-028 When jmp and jmp_nz are asserted together, jmp SHALL win.
REQ-029 When call and jmp are asserted together, the call SHALL be taken and SHALL push.
REQ-030 Latency: a request present in cycle N SHALL appear on pm_addr combinationally in cycle N and in pc at edge N+1.
REQ-031 from_PS SHALL equal pc at all times.
REQ-032 stack_err SHALL remain set until sync_reset.

Reset
REQ-033 While sync_reset=1, pm_addr SHALL be 8'h00, overriding every request including hold.
REQ-034 At the clk edge with sync_reset=1: pc=8'h00, sp=0 and stack_err=0; stack contents are don't-care.
REQ-035 Reset asserted mid-call or mid-hold SHALL abandon that operation; with sync_reset=0 from the next cycle, fetch restarts from 8'h00.

Verification
REQ-036 Reset then free-run for 258 cycles -> pc steps 00,01,...,FF,00,01, and stack_err stays 0.
REQ-037 pc=8'h35 with jmp=1, jmp_addr=4'hA -> pm_addr=8'h3A the same cycle and pc=8'h3A next cycle; repeat with jmp_nz=1: dont_jmp=1 gives pc=8'h36, dont_jmp=0 gives pc=8'h3A.
REQ-038 Five consecutive calls starting from pc=8'h10 (each call one cycle after the previous, with an increment between) -> sp reaches 4 and stack_err is set on the 5th call; then four rets -> pc follows the pushed pc+1 values in LIFO order, and a 5th ret gives pc = previous pc+1 with stack_err still 1.
REQ-039 hold=1 for 3 cycles at pc=8'h22 while jmp and call toggle -> pc stays 8'h22, pm_addr stays 8'h22 and sp is unchanged; after release, pc=8'h23 (or the requested target).
REQ-040 call and ret together with sp=1 and top entry 8'h57 -> pc=8'h57 and sp=0; then jmp and jmp_nz together with dont_jmp=0 and jmp_addr=4'h3 -> pc={pc[7:4],3}.
REQ-041 sync_reset asserted for one cycle at pc=8'hC4 with sp=2 and hold=1 -> pm_addr=8'h00 that cycle; next cycle pc=8'h00, sp=0 and stack_err=0.

Source files
------------

// File: rtl/program_sequencer_ctrl_if.sv
// Decoder-to-sequencer request bundle plus the sequencer's fetch/debug outputs.
interface program_sequencer_ctrl_if;
  logic       jmp;
  logic       jmp_nz;
  logic       call;
  logic       ret;
  logic [3:0] jmp_addr;
  logic       dont_jmp;
  logic       hold;
  logic [7:0] pm_addr;
  logic [7:0] pc;
  logic [7:0] from_PS;
  logic [2:0] sp;
  logic       stack_err;

  modport master (
    output jmp, jmp_nz, call, ret, jmp_addr, dont_jmp, hold,
    input  pm_addr, pc, from_PS, sp, stack_err
  );

  modport slave (
    input  jmp, jmp_nz, call, ret, jmp_addr, dont_jmp, hold,
    output pm_addr, pc, from_PS, sp, stack_err
  );
endinterface

// File: rtl/program_sequencer_ctrl.sv
// Program sequencer: priority-selects the next fetch address and keeps a 4-deep return stack.
// pm_addr is combinational in the request cycle; pc follows one edge later; hold freezes all state.
module program_sequencer_ctrl (
  input  logic                    clk,
  input  logic                    sync_reset,
  program_sequencer_ctrl_if.slave bus
);

  localparam logic [2:0] STACK_DEPTH = 3'd4;

  logic [7:0] pc_q;
  logic [2:0] sp_q;
  logic       err_q;
  logic [7:0] stack_mem [4];

  logic [7:0] pc_inc;
  logic [7:0] target;
  logic [1:0] top_idx;
  logic [7:0] next_addr;
  logic       push;
  logic       pop;
  logic       err_set;

  assign pc_inc  = pc_q + 8'd1;
  assign target  = {pc_q[7:4], bus.jmp_addr};
  assign top_idx = sp_q[1:0] - 2'd1;

  // Fixed priority: reset > hold > ret > call > jmp > jmp_nz taken > increment.
  always_comb begin
    next_addr = pc_inc;
    push      = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
    if (sync_reset) begin
      next_addr = 8'h00;
    end else if (bus.hold) begin
      next_addr = pc_q;
    end else if (bus.ret) begin
      if (sp_q != 3'd0) begin
        next_addr = stack_mem[top_idx];
        pop       = 1'b1;
      end else begin
        next_addr = pc_inc;
        err_set   = 1'b1;
      end
    end else if (bus.call) begin
      next_addr = target;
      if (sp_q < STACK_DEPTH) begin
        push = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end else if (bus.jmp) begin
      next_addr = target;
    end else if (bus.jmp_nz && !bus.dont_jmp) begin
      next_addr = target;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pc_q  <= 8'h00;
      sp_q  <= 3'd0;
      err_q <= 1'b0;
    end else if (!bus.hold) begin
      pc_q <= next_addr;
      if (push) begin
        sp_q <= sp_q + 3'd1;
      end else if (pop) begin
        sp_q <= sp_q - 3'd1;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // Stack contents need no reset; push is already gated by reset and hold.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[sp_q[1:0]] <= pc_inc;
    end
  end

  assign bus.pm_addr   = next_addr;
  assign bus.pc        = pc_q;
  assign bus.from_PS   = pc_q;
  assign bus.sp        = sp_q;
  assign bus.stack_err = err_q;

endmodule

// File: tb/tb_program_sequencer_ctrl.sv
// Directed bench for program_sequencer_ctrl with hand-computed expectations.
module tb_program_sequencer_ctrl;

  logic clk;
  logic sync_reset;
  int   total;
  int   bad;

  program_sequencer_ctrl_if bus ();

  program_sequencer_ctrl dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.jmp      = 1'b0;
    bus.jmp_nz   = 1'b0;
    bus.call     = 1'b0;
    bus.ret      = 1'b0;
    bus.jmp_addr = 4'h0;
    bus.dont_jmp = 1'b0;
    bus.hold     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
  endtask

  task automatic do_call(input logic [3:0] a);
    bus.call = 1'b1;
    bus.jmp_addr = a;
    step();
    bus.call = 1'b0;
  endtask

  task automatic do_ret();
    bus.ret = 1'b1;
    step();
    bus.ret = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();

    // Reset state
    sync_reset = 1'b1;
    #1;
    chk("rst_pm_addr", bus.pm_addr, 8'h00);
    step();
    sync_reset = 1'b0;
    chk("rst_pc", bus.pc, 8'h00);
    chk("rst_sp", {5'd0, bus.sp}, 8'h00);
    chk("rst_err", {7'd0, bus.stack_err}, 8'h00);

    // Free run 00..FF,00,01 with wrap
    for (int i = 1; i <= 257; i++) begin
      step();
      chk("run_pc", bus.pc, 8'(i));
      chk("run_from_ps", bus.from_PS, 8'(i));
    end
    chk("run_err", {7'd0, bus.stack_err}, 8'h00);

    // Jumps from pc=35
    do_reset();
    run(8'h35);
    chk("pre_jmp_pc", bus.pc, 8'h35);
    bus.jmp = 1'b1; bus.jmp_addr = 4'hA;
    #1;
    chk("jmp_pm_addr", bus.pm_addr, 8'h3A);
    step();
    chk("jmp_pc", bus.pc, 8'h3A);
    bus.jmp_addr = 4'h5;
    step();
    bus.jmp = 1'b0;
    chk("jmp_back_pc", bus.pc, 8'h35);
    bus.jmp_nz = 1'b1; bus.dont_jmp = 1'b1; bus.jmp_addr = 4'hA;
    #1;
    chk("jnz_nt_pm_addr", bus.pm_addr, 8'h36);
    step();
    chk("jnz_nt_pc", bus.pc, 8'h36);
    bus.jmp_nz = 1'b0; bus.jmp = 1'b1; bus.jmp_addr = 4'h5;
    step();
    bus.jmp = 1'b0;
    bus.jmp_nz = 1'b1; bus.dont_jmp = 1'b0; bus.jmp_addr = 4'hA;
    step();
    chk("jnz_t_pc", bus.pc, 8'h3A);
    idle();

    // Five calls from pc=10, then five rets
    do_reset();
    run(8'h10);
    do_call(4'h4);
    chk("call1_pc", bus.pc, 8'h14);
    chk("call1_sp", {5'd0, bus.sp}, 8'h01);
    step();
    do_call(4'h8);
    chk("call2_pc", bus.pc, 8'h18);
    step();
    do_call(4'hC);
    chk("call3_pc", bus.pc, 8'h1C);
    chk("call3_sp", {5'd0, bus.sp}, 8'h03);
    step();
    do_call(4'h0);
    chk("call4_pc", bus.pc, 8'h10);
    chk("call4_sp", {5'd0, bus.sp}, 8'h04);
    chk("call4_err", {7'd0, bus.stack_err}, 8'h00);
    step();
    do_call(4'h2);
    chk("call5_pc", bus.pc, 8'h12);
    chk("call5_sp", {5'd0, bus.sp}, 8'h04);
    chk("call5_err", {7'd0, bus.stack_err}, 8'h01);
    do_ret();
    chk("ret1_pc", bus.pc, 8'h1E);
    chk("ret1_sp", {5'd0, bus.sp}, 8'h03);
    do_ret();
    chk("ret2_pc", bus.pc, 8'h1A);
    do_ret();
    chk("ret3_pc", bus.pc, 8'h16);
    do_ret();
    chk("ret4_pc", bus.pc, 8'h11);
    chk("ret4_sp", {5'd0, bus.sp}, 8'h00);
    do_ret();
    chk("ret5_pc", bus.pc, 8'h12);
    chk("ret5_sp", {5'd0, bus.sp}, 8'h00);
    chk("ret5_err", {7'd0, bus.stack_err}, 8'h01);

    // Hold at pc=22 with sp=1 while requests toggle
    do_reset();
    run(8'h20);
    do_call(4'h1);
    step();
    chk("pre_hold_pc", bus.pc, 8'h22);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.jmp  = (i != 1);
      bus.call = (i != 0);
      bus.jmp_addr = 4'h9;
      #1;
      chk("hold_pm_addr", bus.pm_addr, 8'h22);
      step();
      chk("hold_pc", bus.pc, 8'h22);
      chk("hold_sp", {5'd0, bus.sp}, 8'h01);
    end
    idle();
    step();
    chk("hold_release_pc", bus.pc, 8'h23);
    chk("hold_release_err", {7'd0, bus.stack_err}, 8'h00);

    // call+ret with top entry 57, then jmp+jmp_nz, then call+jmp
    do_reset();
    run(8'h56);
    do_call(4'h0);
    chk("pre_cr_pc", bus.pc, 8'h50);
    bus.call = 1'b1; bus.ret = 1'b1; bus.jmp_addr = 4'hF;
    #1;
    chk("cr_pm_addr", bus.pm_addr, 8'h57);
    step();
    idle();
    chk("cr_pc", bus.pc, 8'h57);
    chk("cr_sp", {5'd0, bus.sp}, 8'h00);
    bus.jmp = 1'b1; bus.jmp_nz = 1'b1; bus.dont_jmp = 1'b0; bus.jmp_addr = 4'h3;
    step();
    idle();
    chk("jj_pc", bus.pc, 8'h53);
    bus.call = 1'b1; bus.jmp = 1'b1; bus.jmp_addr = 4'h9;
    step();
    idle();
    chk("cj_pc", bus.pc, 8'h59);
    chk("cj_sp", {5'd0, bus.sp}, 8'h01);
    do_ret();
    chk("cj_ret_pc", bus.pc, 8'h54);
    do_ret();
    chk("uflow_pc", bus.pc, 8'h55);
    chk("uflow_err", {7'd0, bus.stack_err}, 8'h01);

    // Reset during hold at pc=C4, sp=2, stack_err=1
    run(8'hC2 - 8'h55);
    do_call(4'h3);
    do_call(4'h4);
    chk("pre_rst_pc", bus.pc, 8'hC4);
    chk("pre_rst_sp", {5'd0, bus.sp}, 8'h02);
    sync_reset = 1'b1; bus.hold = 1'b1; bus.call = 1'b1; bus.jmp = 1'b1;
    #1;
    chk("mid_rst_pm_addr", bus.pm_addr, 8'h00);
    step();
    sync_reset = 1'b0;
    idle();
    chk("mid_rst_pc", bus.pc, 8'h00);
    chk("mid_rst_sp", {5'd0, bus.sp}, 8'h00);
    chk("mid_rst_err", {7'd0, bus.stack_err}, 8'h00);
    step();
    chk("post_rst_pc", bus.pc, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
